// File: rtl/msm_sclr_win_sched.sv
// Scalar window scheduler: carry-recodes a full scalar into signed C-bit digits and
// streams them to P_NUM_ACCU accumulator lanes, ping-pong buffered so recode overlaps emission.
module msm_sclr_win_sched #(
    parameter int P_FUL_SCLR_W = 256,
    parameter int P_RED_SCLR_W = 13,
    parameter int P_NUM_ACCU   = 3,
    parameter int P_TOTAL_WIN  = (P_FUL_SCLR_W + P_RED_SCLR_W - 1) / P_RED_SCLR_W,
    parameter int P_NUM_WIN    = (P_TOTAL_WIN + P_NUM_ACCU - 1) / P_NUM_ACCU,
    parameter int P_TAG_W      = 32
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [P_FUL_SCLR_W-1:0]             s_scalar,
    input  logic [P_TAG_W-1:0]                  s_tag,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [P_NUM_ACCU*P_RED_SCLR_W-1:0]  m_digit,
    output logic [P_NUM_ACCU-1:0]               m_dvld,
    output logic [2:0]                          m_win,
    output logic [P_TAG_W-1:0]                  m_tag,
    output logic                                m_last,
    output logic                                busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // once m_valid is raised, all m_* payload holds stable until that transfer.

    localparam int C      = P_RED_SCLR_W;
    localparam int N_SLOT = P_NUM_ACCU * P_NUM_WIN;
    localparam int EXT_W  = N_SLOT * C;
    localparam int CNT_W  = (P_NUM_WIN > 1) ? $clog2(P_NUM_WIN) : 1;
    localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam int BASE_W = $clog2(EXT_W);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(P_NUM_WIN - 1);
    localparam logic [C:0]       HALF   = (C + 1)'(1) << (C - 1);

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;
    localparam logic [0:0] E_IDLE = 1'b0;
    localparam logic [0:0] E_RUN  = 1'b1;

    // The top window must have headroom so its carry out is always zero.
    if (P_TOTAL_WIN * C <= P_FUL_SCLR_W) begin : g_win_check
        $error("msm_sclr_win_sched: P_TOTAL_WIN*P_RED_SCLR_W must exceed P_FUL_SCLR_W");
    end

    logic [0:0]              r_state, r_state_d;
    logic [0:0]              e_state, e_state_d;
    logic [CNT_W-1:0]        k_cnt;
    logic [CNT_W-1:0]        j_cnt, j_cnt_d;
    logic                    carry;
    logic                    fill_ptr, fill_ptr_d;
    logic                    drain_ptr, drain_ptr_d;
    logic [1:0]              full, full_d;
    logic                    s_ready_d;
    logic                    r_accept, r_done, e_hs, e_done;

    logic [P_FUL_SCLR_W-1:0] sclr_q;
    logic [C-1:0]            dig_mem [2][N_SLOT];
    logic [P_TAG_W-1:0]      tag_mem [2];
    logic [1:0]              last_mem;

    logic [EXT_W-1:0]        sclr_ext;
    logic [C-1:0]            rc_dig [P_NUM_ACCU];
    logic                    rc_cout;

    assign sclr_ext = {{(EXT_W - P_FUL_SCLR_W){1'b0}}, sclr_q};

    // One beat of the serial carry chain: windows k*P_NUM_ACCU .. k*P_NUM_ACCU+P_NUM_ACCU-1.
    always_comb begin
        logic              c;
        logic [C:0]        t;
        logic [BASE_W-1:0] base;
        int                w;
        c    = carry;
        t    = '0;
        base = '0;
        w    = 0;
        for (int i = 0; i < P_NUM_ACCU; i++) begin
            w    = int'(k_cnt) * P_NUM_ACCU + i;
            base = BASE_W'(w * C);
            t    = {1'b0, sclr_ext[base +: C]} + {{C{1'b0}}, c};
            if (w < P_TOTAL_WIN) begin
                rc_dig[i] = t[C-1:0];
                c         = (t >= HALF);
            end else begin
                rc_dig[i] = '0;
                c         = 1'b0;
            end
        end
        rc_cout = c;
    end

    always_comb begin
        r_accept = s_valid && s_ready;
        r_done   = (r_state == R_RUN) && (k_cnt == LAST_K);
        e_hs     = (e_state == E_RUN) && m_ready;
        e_done   = e_hs && (j_cnt == LAST_K);

        full_d = full;
        if (r_done) full_d[fill_ptr] = 1'b1;
        if (e_done) full_d[drain_ptr] = 1'b0;

        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (r_accept) r_state_d = R_RUN;
            default: if (r_done)   r_state_d = R_IDLE;
        endcase
        fill_ptr_d = fill_ptr ^ r_done;
        // Registered ready sees buffers freed on this same edge.
        s_ready_d  = (r_state_d == R_IDLE) && !full_d[fill_ptr_d];

        e_state_d   = e_state;
        j_cnt_d     = j_cnt;
        drain_ptr_d = drain_ptr;
        case (e_state)
            E_IDLE: begin
                if (full[drain_ptr]) begin
                    e_state_d = E_RUN;
                    j_cnt_d   = '0;
                end
            end
            default: begin
                if (e_done) begin
                    drain_ptr_d = !drain_ptr;
                    j_cnt_d     = '0;
                    e_state_d   = full[!drain_ptr] ? E_RUN : E_IDLE;
                end else if (e_hs) begin
                    j_cnt_d = j_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= R_IDLE;
            e_state   <= E_IDLE;
            k_cnt     <= '0;
            j_cnt     <= '0;
            carry     <= 1'b0;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            full      <= '0;
            s_ready   <= 1'b0;
        end else begin
            r_state   <= r_state_d;
            e_state   <= e_state_d;
            j_cnt     <= j_cnt_d;
            fill_ptr  <= fill_ptr_d;
            drain_ptr <= drain_ptr_d;
            full      <= full_d;
            s_ready   <= s_ready_d;
            if (r_accept) begin
                k_cnt <= '0;
                carry <= 1'b0;
            end else if (r_state == R_RUN) begin
                k_cnt <= k_cnt + CNT_W'(1);
                carry <= rc_cout;
            end
        end
    end

    // Payload storage needs no reset: the full flags alone qualify it.
    always_ff @(posedge ap_clk) begin
        if (r_accept) begin
            sclr_q             <= s_scalar;
            tag_mem[fill_ptr]  <= s_tag;
            last_mem[fill_ptr] <= s_last;
        end
        if (r_state == R_RUN) begin
            for (int i = 0; i < P_NUM_ACCU; i++) begin
                dig_mem[fill_ptr][SLOT_W'(int'(k_cnt) * P_NUM_ACCU + i)] <= rc_dig[i];
            end
        end
    end

    always_comb begin
        int slot;
        slot    = 0;
        m_valid = (e_state == E_RUN);
        m_digit = '0;
        m_dvld  = '0;
        m_win   = '0;
        m_tag   = '0;
        m_last  = 1'b0;
        if (m_valid) begin
            for (int a = 0; a < P_NUM_ACCU; a++) begin
                slot               = a * P_NUM_WIN + int'(j_cnt);
                m_digit[a*C +: C]  = dig_mem[drain_ptr][SLOT_W'(slot)];
                m_dvld[a]          = (slot < P_TOTAL_WIN);
            end
            m_win  = 3'(j_cnt);
            m_tag  = tag_mem[drain_ptr];
            m_last = last_mem[drain_ptr] && (j_cnt == LAST_K);
        end
    end

    assign busy = (r_state == R_RUN) || (|full);

endmodule
